// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller time-sharing one external 1-bit full adder, LSB first.
// Build option SERIAL_ADD_SUB_EN adds a sub port selecting a - b.
//
// state | meaning
// IDLE  | waiting for start; adder inputs held at 0
// RUN   | one operand bit per clock through the external adder
// DONE  | one-cycle done pulse, result valid
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_s,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as a + ~b + 1, so cout=1 signals no borrow.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub ? 1'b1 : cin;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 1'b0;
        add_b   = 1'b0;
        add_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_sh[0];
                add_b   = b_sh[0];
                add_cin = carry;
                last    = (count == CW'(WIDTH - 1));
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= cin_load;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state_q == RUN) begin
            // Sum fills from the top so after WIDTH shifts bit 0 lands at sum[0].
            sum   <= {add_s, sum[WIDTH-1:1]};
            carry <= add_cout;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            count <= count + CW'(1);
            if (last) begin
                cout <= add_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a behavioural full adder on the adder ports.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             add_a;
    logic             add_b;
    logic             add_cin;
    logic             add_s;
    logic             add_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign add_s    = add_a ^ add_b ^ add_cin;
    assign add_cout = (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the bench at the negedge just after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_add(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vc, input logic [WIDTH-1:0] es, input logic ec);
        int cyc;
        start_op(va, vb, vc);
        wait_done(cyc);
        tests_run++;
        if (done !== 1'b1 || cyc != WIDTH) begin
            tests_failed++;
            $display("FAIL %s latency: done=%b after %0d cycles, required done=1 after %0d", name, done, cyc, WIDTH);
        end
        tests_run++;
        if (sum !== es || cout !== ec) begin
            tests_failed++;
            $display("FAIL %s result: sum=%h cout=%b, required sum=%h cout=%b", name, sum, cout, es, ec);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_in_done: busy=%b, required 1", name, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== es || cout !== ec) begin
            tests_failed++;
            $display("FAIL %s after_done: done=%b busy=%b sum=%h cout=%b, required 0 0 %h %b",
                     name, done, busy, sum, cout, es, ec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", busy, done, sum, cout);
        end
        tests_run++;
        if (add_a !== 1'b0 || add_b !== 1'b0 || add_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_adder_ports: a=%b b=%b cin=%b, required 0 0 0", add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_ripple();
        start_op(8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            tests_run++;
            if (add_a !== 1'b1 || add_b !== (i == 0) || add_cin !== (i != 0)) begin
                tests_failed++;
                $display("FAIL ripple_bit%0d: add_a=%b add_b=%b add_cin=%b, required 1 %b %b",
                         i, add_a, add_b, add_cin, (i == 0), (i != 0));
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL ripple_result: done=%b sum=%h cout=%b, required 1 00 1", done, sum, cout);
        end
        @(negedge clk);
        tests_run++;
        if (add_a !== 1'b0 || add_b !== 1'b0 || add_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_adder_ports: a=%b b=%b cin=%b, required 0 0 0", add_a, add_b, add_cin);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        start_op(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_busy: busy=%b, required 1", busy);
        end
        wait_done(cyc);
        tests_run++;
        if (done !== 1'b1 || cyc != WIDTH - 4) begin
            tests_failed++;
            $display("FAIL ignore_latency: done=%b after %0d more cycles, required done=1 after %0d",
                     done, cyc, WIDTH - 4);
        end
        tests_run++;
        if (sum !== 8'h10 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_result: sum=%h cout=%b, required 10 0", sum, cout);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_no_restart: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        a     = 8'h03;
        b     = 8'h04;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        wait_done(cyc);
        tests_run++;
        if (done !== 1'b1 || cyc != WIDTH || sum !== 8'h07 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b cycles=%0d sum=%h cout=%b, required 1 %0d 07 0",
                     done, cyc, sum, cout, WIDTH);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || sum !== 8'h00) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy=%b sum=%h, required 1 00", busy, sum);
        end
        wait_done(cyc);
        tests_run++;
        if (done !== 1'b1 || cyc != WIDTH || sum !== 8'h30 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: done=%b cycles=%0d sum=%h cout=%b, required 1 %0d 30 0",
                     done, cyc, sum, cout, WIDTH);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        start_op(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || add_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: busy=%b done=%b sum=%h cout=%b add_cin=%b, required 0 0 00 0 0",
                     busy, done, sum, cout, add_cin);
        end
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done) begin
            tests_failed++;
            $display("FAIL abort_no_done: activity seen=%b, required 0", seen_done);
        end
        test_add("abort_restart", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        sub = 1'b1;
        test_add("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        test_add("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        sub = 1'b0;
        test_add("sub_off", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        test_ripple();
        test_add("5a_a5_c1", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        test_add("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        test_add("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        test_add("c8_64_c1", 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1);
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
